// File: rtl/and_frame_reducer_pkg.sv
// Shared definitions for the AND frame reducer and its bench.
package and_frame_reducer_pkg;

   // Frame-collection state: ACCUM gathers words, HOLD presents the result.
   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam int DEF_WIDTH     = 16;
   localparam int DEF_FRAME_LEN = 4;

endpackage

// File: rtl/and_frame_reducer_popcount16.sv
// Combinational 16-bit ones counter, built as a balanced adder tree.
module popcount16 (
   input  logic [15:0] din,
   output logic [4:0]  cnt
);

   logic [7:0][1:0] l1;
   logic [3:0][2:0] l2;
   logic [1:0][3:0] l3;

   // Level 1: bit pairs -> 2-bit partial sums.
   for (genvar i = 0; i < 8; i++) begin : g_l1
      assign l1[i] = {1'b0, din[2*i]} + {1'b0, din[2*i+1]};
   end

   // Level 2: nibbles -> 3-bit partial sums.
   for (genvar i = 0; i < 4; i++) begin : g_l2
      assign l2[i] = {1'b0, l1[2*i]} + {1'b0, l1[2*i+1]};
   end

   // Level 3: bytes -> 4-bit partial sums.
   for (genvar i = 0; i < 2; i++) begin : g_l3
      assign l3[i] = {1'b0, l2[2*i]} + {1'b0, l2[2*i+1]};
   end

   assign cnt = {1'b0, l3[0]} + {1'b0, l3[1]};

endmodule

// File: rtl/and_frame_reducer.sv
// AND-reduces FRAME_LEN accepted words into one frame mask and presents the
// mask, its popcount and a zero flag on a held valid/ready output.
module and_frame_reducer
   import and_frame_reducer_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int FRAME_LEN = DEF_FRAME_LEN,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [4:0]       out_pop,
   output logic             out_zero
);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   nxt_res;
   logic [15:0]        pc_in;
   logic [4:0]         pc_out;
   logic               accept;
   logic               last;

   // Running reduction including the word on the bus; becomes the frame
   // result when this is the last word.
   assign nxt_res = acc & in_data;
   assign pc_in   = 16'(nxt_res);

   popcount16 u_pop (
      .din (pc_in),
      .cnt (pc_out)
   );

   // Handshake decode and next state; clr blocks acceptance even though
   // in_ready still reads 1 in ACCUM.
   always_comb begin
      state_d  = state_q;
      in_ready = (state_q == ACCUM);
      accept   = in_valid && in_ready && !clr;
      last     = accept && (cnt == CNT_W'(FRAME_LEN - 1));
      if (clr)
         state_d = ACCUM;
      else if (state_q == ACCUM && last)
         state_d = HOLD;
      else if (state_q == HOLD && out_ready)
         state_d = ACCUM;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ACCUM;
      else        state_q <= state_d;
   end

   // Accumulator, word counter and registered result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '1;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_pop   <= '0;
         out_zero  <= 1'b0;
      end else if (clr) begin
         acc       <= '1;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_pop   <= '0;
         out_zero  <= 1'b0;
      end else if (state_q == ACCUM) begin
         if (last) begin
            // Frame complete: latch result, re-arm for the next frame.
            acc       <= '1;
            cnt       <= '0;
            out_valid <= 1'b1;
            out_data  <= nxt_res;
            out_pop   <= pc_out;
            out_zero  <= (nxt_res == '0);
         end else if (accept) begin
            acc <= nxt_res;
            cnt <= cnt + 1'b1;
         end
      end else if (out_ready) begin
         // Result consumed; out_data/out_pop/out_zero keep their values.
         acc       <= '1;
         cnt       <= '0;
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_and_frame_reducer.sv
// Directed self-checking bench for and_frame_reducer.
module tb_and_frame_reducer;
   import and_frame_reducer_pkg::*;

   localparam int W = DEF_WIDTH;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         clr;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic [4:0]   out_pop;
   logic         out_zero;

   int total = 0;
   int bad   = 0;

   and_frame_reducer #(.WIDTH(W), .FRAME_LEN(DEF_FRAME_LEN), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_pop   (out_pop),
      .out_zero  (out_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs set afterwards apply at the next edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one word and clock it in.
   task automatic put(input logic [W-1:0] w);
      in_valid = 1'b1;
      in_data  = w;
      step();
      in_valid = 1'b0;
   endtask

   logic [W-1:0] f1 [4];
   logic [W-1:0] f2 [4];
   logic [W-1:0] gap [7];
   logic         gapv [7];

   initial begin
      f1   = '{16'hFFFF, 16'hF0F0, 16'hFF00, 16'hF000};
      f2   = '{16'h00FF, 16'hFF00, 16'hFFFF, 16'hFFFF};
      gap  = '{16'h8001, 16'h0000, 16'h0000, 16'h8003, 16'h0000, 16'hFFFF, 16'h8001};
      gapv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;

      // Reset / idle state
      repeat (5) step();
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data",  out_data,  0);
      chk("rst_out_pop",   out_pop,   0);
      chk("rst_out_zero",  out_zero,  0);

      // Back-to-back frame, consumer always ready
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("f1_in_ready", in_ready, 1);
         chk("f1_no_valid", out_valid, 0);
         put(f1[i]);
      end
      chk("f1_valid", out_valid, 1);
      chk("f1_data",  out_data,  16'hF000);
      chk("f1_pop",   out_pop,   4);
      chk("f1_zero",  out_zero,  0);
      chk("f1_hold_ready", in_ready, 0);
      step();
      chk("f1_one_cycle", out_valid, 0);
      chk("f1_back_ready", in_ready, 1);
      chk("f1_data_kept", out_data, 16'hF000);

      // Zero result with consumer stalled; offered word must not be taken
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) put(f2[i]);
      in_valid = 1'b1; in_data = 16'h0000;
      for (int i = 0; i < 3; i++) begin
         chk("f2_valid", out_valid, 1);
         chk("f2_data",  out_data,  0);
         chk("f2_zero",  out_zero,  1);
         chk("f2_pop",   out_pop,   0);
         chk("f2_in_ready", in_ready, 0);
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      chk("f2_released", out_valid, 0);

      // Frame with idle gaps; result only after the 4th accepted word
      for (int i = 0; i < 7; i++) begin
         chk("gap_no_valid", out_valid, 0);
         in_valid = gapv[i];
         in_data  = gap[i];
         step();
      end
      in_valid = 1'b0;
      chk("gap_valid", out_valid, 1);
      chk("gap_data",  out_data,  16'h8001);
      chk("gap_pop",   out_pop,   2);
      step();

      // clr aborts a partial frame; the clr-cycle word is dropped
      put(16'h0F0F);
      put(16'h00FF);
      clr = 1'b1; in_valid = 1'b1; in_data = 16'h0000;
      step();
      clr = 1'b0; in_valid = 1'b0;
      chk("clr_valid", out_valid, 0);
      chk("clr_data",  out_data,  0);
      chk("clr_ready", in_ready,  1);
      for (int i = 0; i < 3; i++) begin
         put(16'h1234);
         chk("clr_no_early", out_valid, 0);
      end
      put(16'h1234);
      chk("clr_f_valid", out_valid, 1);
      chk("clr_f_data",  out_data,  16'h1234);
      chk("clr_f_pop",   out_pop,   5);
      step();

      // Asynchronous reset while holding a result
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) put(f1[i]);
      chk("ar_valid_pre", out_valid, 1);
      chk("ar_data_pre",  out_data,  16'hF000);
      #1 rst_n = 1'b0;
      #1;
      chk("ar_valid", out_valid, 0);
      chk("ar_data",  out_data,  0);
      chk("ar_ready", in_ready,  1);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         put(16'hFFFF);
         chk("ar_no_early", out_valid, 0);
      end
      put(16'hFFFF);
      chk("ar_f_valid", out_valid, 1);
      chk("ar_f_data",  out_data,  16'hFFFF);
      chk("ar_f_pop",   out_pop,   16);
      chk("ar_f_zero",  out_zero,  0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
